// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared types and constants for the divider issue controller.
//   - issue FSM state encoding (IDLE/BUSY/RESP)
//   - operand width, the signed-overflow dividend and the all-ones pattern
//   - result-select encodings (quotient / remainder)
package div_issue_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } div_state_t;

    localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES         = '1;

    localparam logic RES_SEL_QUOT = 1'b0;
    localparam logic RES_SEL_REM  = 1'b1;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: request/response link between the EX-stage issue
// controller and the iterative divider.
//   ex_is_div_inst  request level (divider starts on its rising edge)
//   ex_div_sign     1 = signed operation
//   ex_div_res_sel  0 = quotient, 1 = remainder
//   dividend/divisor held operands
//   div_done        divider completion strobe
//   div_res         divider result, valid with div_done
// Modports: master = issue controller, slave = divider.
interface div_issue_ctrl_if #(
    parameter int XLEN = div_issue_ctrl_pkg::XLEN
);
    logic            ex_is_div_inst;
    logic            ex_div_sign;
    logic            ex_div_res_sel;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_done;
    logic [XLEN-1:0] div_res;

    modport master (
        output ex_is_div_inst, ex_div_sign, ex_div_res_sel, dividend, divisor,
        input  div_done, div_res
    );

    modport slave (
        input  ex_is_div_inst, ex_div_sign, ex_div_res_sel, dividend, divisor,
        output div_done, div_res
    );
endinterface

// File: rtl/div_issue_ctrl_special.sv
// div_special_case: combinational detection of the operand pairs the
// controller answers without the divider.
//   rs1, rs2  dividend / divisor
//   sign      1 = signed
//   res_sel   0 = quotient, 1 = remainder
//   hit       operands are divide-by-zero or signed overflow
//   res       architectural result for the hit case
module div_special_case
    import div_issue_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            sign,
    input  logic            res_sel,
    output logic            hit,
    output logic [XLEN-1:0] res
);
    logic div_zero;
    logic ovf;

    assign div_zero = (rs2 == '0);
    // Only the signed most-negative / -1 pair overflows.
    assign ovf      = sign && (rs1 == DIV_OVF_DIVIDEND) && (rs2 == ALL_ONES);

    always_comb begin
        hit = div_zero || ovf;
        res = '0;
        if (div_zero)
            res = (res_sel == RES_SEL_REM) ? rs1 : ALL_ONES;
        else if (ovf)
            res = (res_sel == RES_SEL_REM) ? '0 : DIV_OVF_DIVIDEND;
    end
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage initiator for the iterative divider.
// Accepts DIV/DIVU/REM/REMU from ID/EX, latches operands, drives the divider
// request, stalls the pipeline until completion and emits a one-cycle
// writeback. Divide-by-zero and signed overflow resolve locally.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_ex_*           incoming instruction and operands
//   flush             kills the in-flight op
//   div               divider link (master side)
//   stall             freeze IF/ID/EX
//   wb_valid/rd/data  writeback strobe, index and value
//   div_timeout       one-cycle pulse when the divider never answered
// Optional macro DIV_RES_REUSE_EN: remember the last divider result and
// answer an identical op without re-issuing it.
module div_issue_ctrl #(
    parameter int XLEN           = div_issue_ctrl_pkg::XLEN,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RD_W           = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_ex_valid,
    input  logic            id_ex_is_div,
    input  logic            id_ex_div_sign,
    input  logic            id_ex_div_res_sel,
    input  logic [XLEN-1:0] id_ex_rs1,
    input  logic [XLEN-1:0] id_ex_rs2,
    input  logic [RD_W-1:0] id_ex_rd,
    input  logic            flush,
    div_issue_ctrl_if.master div,
    output logic            stall,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            div_timeout
);
    import div_issue_ctrl_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    div_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d;
    logic [RD_W-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic            sign_q, sign_d, sel_q, sel_d, tmo_q, tmo_d;
    logic            accept, sc_hit;
    logic [XLEN-1:0] sc_res;

    div_special_case u_special (
        .rs1     (id_ex_rs1),
        .rs2     (id_ex_rs2),
        .sign    (id_ex_div_sign),
        .res_sel (id_ex_div_res_sel),
        .hit     (sc_hit),
        .res     (sc_res)
    );

`ifdef DIV_RES_REUSE_EN
    logic            tag_vld_q, tag_vld_d;
    logic [XLEN-1:0] tag_rs1_q, tag_rs1_d, tag_rs2_q, tag_rs2_d, tag_res_q, tag_res_d;
    logic            tag_sign_q, tag_sign_d, tag_sel_q, tag_sel_d;
    logic            reuse_hit;

    assign reuse_hit = tag_vld_q && (tag_rs1_q == id_ex_rs1) && (tag_rs2_q == id_ex_rs2)
                    && (tag_sign_q == id_ex_div_sign) && (tag_sel_q == id_ex_div_res_sel);
`endif

    assign accept = id_ex_valid && id_ex_is_div && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        sign_d   = sign_q;
        sel_d    = sel_q;
        res_d    = res_q;
        wb_rd_d  = wb_rd_q;
        tmo_d    = 1'b0;
        stall    = 1'b0;
        wb_valid = 1'b0;
`ifdef DIV_RES_REUSE_EN
        tag_vld_d  = flush ? 1'b0 : tag_vld_q;
        tag_rs1_d  = tag_rs1_q;
        tag_rs2_d  = tag_rs2_q;
        tag_sign_d = tag_sign_q;
        tag_sel_d  = tag_sel_q;
        tag_res_d  = tag_res_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall  = 1'b1;
                    rs1_d  = id_ex_rs1;
                    rs2_d  = id_ex_rs2;
                    rd_d   = id_ex_rd;
                    sign_d = id_ex_div_sign;
                    sel_d  = id_ex_div_res_sel;
                    if (sc_hit) begin
                        res_d   = sc_res;
                        wb_rd_d = id_ex_rd;
                        state_d = ST_RESP;
                    end
`ifdef DIV_RES_REUSE_EN
                    else if (reuse_hit) begin
                        res_d   = tag_res_q;
                        wb_rd_d = id_ex_rd;
                        state_d = ST_RESP;
                    end
`endif
                    else begin
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // flush beats a coincident div_done
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div.div_done) begin
                    res_d   = div.div_res;
                    wb_rd_d = rd_q;
                    state_d = ST_RESP;
`ifdef DIV_RES_REUSE_EN
                    tag_vld_d  = 1'b1;
                    tag_rs1_d  = rs1_q;
                    tag_rs2_d  = rs2_q;
                    tag_sign_d = sign_q;
                    tag_sel_d  = sel_q;
                    tag_res_d  = div.div_res;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
`ifdef DIV_RES_REUSE_EN
                    tag_vld_d = 1'b0;
`endif
                end
            end
            ST_RESP: begin
                // Always return to IDLE: the request stays low through RESP
                // and the following accept cycle, giving the divider a clean
                // rising edge for the next op.
                wb_valid = !flush;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            sign_q  <= 1'b0;
            sel_q   <= 1'b0;
            res_q   <= '0;
            wb_rd_q <= '0;
            tmo_q   <= 1'b0;
`ifdef DIV_RES_REUSE_EN
            tag_vld_q  <= 1'b0;
            tag_rs1_q  <= '0;
            tag_rs2_q  <= '0;
            tag_sign_q <= 1'b0;
            tag_sel_q  <= 1'b0;
            tag_res_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            sign_q  <= sign_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            wb_rd_q <= wb_rd_d;
            tmo_q   <= tmo_d;
`ifdef DIV_RES_REUSE_EN
            tag_vld_q  <= tag_vld_d;
            tag_rs1_q  <= tag_rs1_d;
            tag_rs2_q  <= tag_rs2_d;
            tag_sign_q <= tag_sign_d;
            tag_sel_q  <= tag_sel_d;
            tag_res_q  <= tag_res_d;
`endif
        end
    end

    assign div.ex_is_div_inst = (state_q == ST_BUSY);
    assign div.ex_div_sign    = sign_q;
    assign div.ex_div_res_sel = sel_q;
    assign div.dividend       = rs1_q;
    assign div.divisor        = rs2_q;
    assign wb_rd              = wb_rd_q;
    assign wb_data            = res_q;
    assign div_timeout        = tmo_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench for div_issue_ctrl. The bench plays the
// divider, replying with hand-computed results after a chosen latency.
module tb_div_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_ex_valid, id_ex_is_div, id_ex_div_sign, id_ex_div_res_sel;
    logic [31:0] id_ex_rs1, id_ex_rs2;
    logic [4:0]  id_ex_rd;
    logic        flush;
    logic        stall, wb_valid, div_timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_pass = 0;
    int n_tot  = 0;

    div_issue_ctrl_if #(.XLEN(32)) dif ();

    div_issue_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(64), .RD_W(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_ex_valid       (id_ex_valid),
        .id_ex_is_div      (id_ex_is_div),
        .id_ex_div_sign    (id_ex_div_sign),
        .id_ex_div_res_sel (id_ex_div_res_sel),
        .id_ex_rs1         (id_ex_rs1),
        .id_ex_rs2         (id_ex_rs2),
        .id_ex_rd          (id_ex_rd),
        .flush             (flush),
        .div               (dif.master),
        .stall             (stall),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .div_timeout       (div_timeout)
    );

    always #5 clk = ~clk;

    // Track the shortest low run of the request between two high runs.
    int   low_run = 0;
    int   min_gap = 1000;
    logic seen_high = 1'b0;
    always @(negedge clk) begin
        if (dif.ex_is_div_inst && low_run > 0 && seen_high && low_run < min_gap)
            min_gap = low_run;
        if (dif.ex_is_div_inst) begin
            low_run   = 0;
            seen_high = 1'b1;
        end else begin
            low_run++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic sel, input logic [4:0] rd);
        id_ex_valid       = 1'b1;
        id_ex_is_div      = 1'b1;
        id_ex_rs1         = a;
        id_ex_rs2         = b;
        id_ex_div_sign    = sgn;
        id_ex_div_res_sel = sel;
        id_ex_rd          = rd;
    endtask

    task automatic idle_in();
        id_ex_valid  = 1'b0;
        id_ex_is_div = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        flush = 1'b0;
        dif.div_done = 1'b0;
        dif.div_res  = '0;
        id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
        id_ex_div_sign = 1'b0; id_ex_div_res_sel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_tot++;
        if ({stall, wb_valid, div_timeout, dif.ex_is_div_inst} !== 4'b0)
            $display("FAIL reset_ctl: got %b want 0000", {stall, wb_valid, div_timeout, dif.ex_is_div_inst});
        else n_pass++;
        n_tot++;
        if ({wb_data, wb_rd, dif.dividend, dif.divisor} !== '0)
            $display("FAIL reset_regs: got %h/%h/%h/%h want 0", wb_data, wb_rd, dif.dividend, dif.divisor);
        else n_pass++;
    endtask

    // Full divider round trip; the divider answers in BUSY cycle lat.
    task automatic test_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic sel, input logic [4:0] rd,
                            input int lat, input logic [31:0] exp);
        int stall_cnt;
        logic ops_ok;
        @(negedge clk);
        issue(a, b, sgn, sel, rd);
        #1;
        n_tot++;
        if (stall !== 1'b1 || dif.ex_is_div_inst !== 1'b0)
            $display("FAIL %s accept: stall=%b req=%b want 1/0", nm, stall, dif.ex_is_div_inst);
        else n_pass++;
        stall_cnt = 1;
        ops_ok = 1'b1;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            idle_in();
            if (stall === 1'b1) stall_cnt++;
            if (dif.ex_is_div_inst !== 1'b1 || dif.dividend !== a || dif.divisor !== b ||
                dif.ex_div_sign !== sgn || dif.ex_div_res_sel !== sel) ops_ok = 1'b0;
            if (i == lat) begin
                dif.div_done = 1'b1;
                dif.div_res  = exp;
            end
        end
        @(negedge clk);
        dif.div_done = 1'b0;
        n_tot++;
        if (!ops_ok) $display("FAIL %s busy_hold: got unstable request want steady operands", nm);
        else n_pass++;
        n_tot++;
        if (stall_cnt !== lat + 1) $display("FAIL %s stall_len: got %0d want %0d", nm, stall_cnt, lat + 1);
        else n_pass++;
        n_tot++;
        if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== rd || stall !== 1'b0 || dif.ex_is_div_inst !== 1'b0)
            $display("FAIL %s wb: v=%b d=%h rd=%0d stall=%b req=%b want 1/%h/%0d/0/0",
                     nm, wb_valid, wb_data, wb_rd, stall, dif.ex_is_div_inst, exp, rd);
        else n_pass++;
    endtask

    task automatic test_special(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input logic sgn, input logic sel, input logic [4:0] rd,
                                input logic [31:0] exp);
        @(negedge clk);
        issue(a, b, sgn, sel, rd);
        #1;
        n_tot++;
        if (stall !== 1'b1) $display("FAIL %s accept_stall: got %b want 1", nm, stall);
        else n_pass++;
        @(negedge clk);
        idle_in();
        n_tot++;
        if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== rd || dif.ex_is_div_inst !== 1'b0 || stall !== 1'b0)
            $display("FAIL %s wb: v=%b d=%h rd=%0d req=%b stall=%b want 1/%h/%0d/0/0",
                     nm, wb_valid, wb_data, wb_rd, dif.ex_is_div_inst, stall, exp, rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        test_div("s_m8_m5_q", 32'hFFFF_FFF8, 32'hFFFF_FFFB, 1'b1, 1'b0, 5'd3, 34, 32'h0000_0001);
        test_div("s_m8_m5_r", 32'hFFFF_FFF8, 32'hFFFF_FFFB, 1'b1, 1'b1, 5'd4, 34, 32'hFFFF_FFFD);
        test_div("u_99_11_q", 32'd99, 32'd11, 1'b0, 1'b0, 5'd5, 34, 32'd9);
        @(negedge clk);
        n_tot++;
        if (wb_valid !== 1'b0 || wb_data !== 32'd9 || wb_rd !== 5'd5)
            $display("FAIL wb_hold: v=%b d=%h rd=%0d want 0/00000009/5", wb_valid, wb_data, wb_rd);
        else n_pass++;
        test_div("s_89_m11_q", 32'd89, 32'hFFFF_FFF5, 1'b1, 1'b0, 5'd6, 20, 32'hFFFF_FFF8);
        test_div("s_89_m11_r", 32'd89, 32'hFFFF_FFF5, 1'b1, 1'b1, 5'd7, 20, 32'h0000_0001);
    endtask

    task automatic test_special_cases();
        test_special("dz_q",  32'h0000_1234, 32'h0, 1'b0, 1'b0, 5'd8,  32'hFFFF_FFFF);
        test_special("dz_r",  32'h0000_1234, 32'h0, 1'b0, 1'b1, 5'd9,  32'h0000_1234);
        test_special("ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd10, 32'h8000_0000);
        test_special("ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd11, 32'h0000_0000);
    endtask

    task automatic test_flush();
        logic bad;
        // flush in IDLE blocks the accept
        @(negedge clk);
        issue(32'd50, 32'd7, 1'b0, 1'b0, 5'd12);
        flush = 1'b1;
        #1;
        n_tot++;
        if (stall !== 1'b0) $display("FAIL flush_idle_stall: got %b want 0", stall);
        else n_pass++;
        @(negedge clk);
        idle_in();
        flush = 1'b0;
        n_tot++;
        if (dif.ex_is_div_inst !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL flush_idle_noacc: req=%b v=%b want 0/0", dif.ex_is_div_inst, wb_valid);
        else n_pass++;
        // flush in BUSY cycle 10 together with div_done
        @(negedge clk);
        issue(32'd50, 32'd7, 1'b0, 1'b0, 5'd12);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            idle_in();
        end
        flush = 1'b1;
        dif.div_done = 1'b1;
        dif.div_res  = 32'd7;
        @(negedge clk);
        flush = 1'b0;
        n_tot++;
        if (dif.ex_is_div_inst !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0)
            $display("FAIL flush_busy: req=%b v=%b stall=%b want 0/0/0", dif.ex_is_div_inst, wb_valid, stall);
        else n_pass++;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wb_valid !== 1'b0 || stall !== 1'b0 || dif.ex_is_div_inst !== 1'b0) bad = 1'b1;
        end
        dif.div_done = 1'b0;
        n_tot++;
        if (bad || wb_data !== 32'h0) $display("FAIL late_done: bad=%b d=%h want 0/00000000", bad, wb_data);
        else n_pass++;
        // flush in RESP suppresses the writeback
        @(negedge clk);
        issue(32'h55, 32'h0, 1'b0, 1'b0, 5'd13);
        @(negedge clk);
        idle_in();
        flush = 1'b1;
        #1;
        n_tot++;
        if (wb_valid !== 1'b0) $display("FAIL flush_resp: got %b want 0", wb_valid);
        else n_pass++;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_rst_busy();
        @(negedge clk);
        issue(32'd1000, 32'd3, 1'b0, 1'b0, 5'd14);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            idle_in();
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dif.div_done = 1'b1;
        dif.div_res  = 32'd333;
        n_tot++;
        if (dif.ex_is_div_inst !== 1'b0 || stall !== 1'b0 || dif.dividend !== 32'h0 || wb_data !== 32'h0)
            $display("FAIL rst_busy: req=%b stall=%b dvd=%h d=%h want 0/0/0/0",
                     dif.ex_is_div_inst, stall, dif.dividend, wb_data);
        else n_pass++;
        @(negedge clk);
        dif.div_done = 1'b0;
        n_tot++;
        if (wb_valid !== 1'b0) $display("FAIL rst_late_done: got %b want 0", wb_valid);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        @(negedge clk);
        issue(32'd77, 32'd5, 1'b0, 1'b1, 5'd15);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            idle_in();
            if (dif.ex_is_div_inst === 1'b1 && div_timeout === 1'b0) hi++;
        end
        n_tot++;
        if (hi !== 64) $display("FAIL tmo_busy_len: got %0d want 64", hi);
        else n_pass++;
        @(negedge clk);
        n_tot++;
        if (div_timeout !== 1'b1 || stall !== 1'b0 || wb_valid !== 1'b0 || dif.ex_is_div_inst !== 1'b0)
            $display("FAIL tmo_pulse: tmo=%b stall=%b v=%b req=%b want 1/0/0/0",
                     div_timeout, stall, wb_valid, dif.ex_is_div_inst);
        else n_pass++;
        @(negedge clk);
        n_tot++;
        if (div_timeout !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL tmo_one_cycle: tmo=%b v=%b want 0/0", div_timeout, wb_valid);
        else n_pass++;
    endtask

    task automatic test_reuse();
        test_div("reuse_seed", 32'd99, 32'd11, 1'b0, 1'b0, 5'd16, 34, 32'd9);
        @(negedge clk);
        issue(32'd99, 32'd11, 1'b0, 1'b0, 5'd17);
        @(negedge clk);
        idle_in();
`ifdef DIV_RES_REUSE_EN
        n_tot++;
        if (dif.ex_is_div_inst !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'd9 || wb_rd !== 5'd17)
            $display("FAIL reuse_hit: req=%b v=%b d=%h rd=%0d want 0/1/00000009/17",
                     dif.ex_is_div_inst, wb_valid, wb_data, wb_rd);
        else n_pass++;
`else
        n_tot++;
        if (dif.ex_is_div_inst !== 1'b1 || wb_valid !== 1'b0)
            $display("FAIL no_reuse: req=%b v=%b want 1/0", dif.ex_is_div_inst, wb_valid);
        else n_pass++;
        dif.div_done = 1'b1;
        dif.div_res  = 32'd9;
        @(negedge clk);
        dif.div_done = 1'b0;
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_special_cases();
        test_flush();
        test_rst_busy();
        test_timeout();
        test_reuse();
        n_tot++;
        if (min_gap < 2) $display("FAIL req_gap: got %0d want >=2", min_gap);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
